seq_pattern_detector: RTL and testbench
=======================================

# seq_pattern_detector

Parametrised serial sequence detector that generalises the fixed two-bit "0 then 1" detector. It matches a run-time-loadable pattern of WIDTH bits on a qualified serial input stream. It supports overlapping and non-overlapping match modes and keeps a saturating match counter. It sits directly on the serial bit stream in the sequence_detector area and feeds match pulses and counts to downstream control and status logic.

## Interface
Parameters:
- WIDTH, 2, pattern length in bits; legal range 2..16.
- OVERLAP, 1, match mode: 1 lets a match's trailing bits start the next match; 0 restarts detection after every match.
- CNT_W, 8, width of the match counter.
- RST_PATTERN, 2'b01 (WIDTH bits), pattern register value after reset.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- A  in  1  serial data bit.
- in_valid  in  1  A is sampled only when in_valid=1.
- pattern  in  WIDTH  new pattern; first expected bit is pattern[WIDTH-1].
- pattern_load  in  1  capture `pattern` this cycle.
- Y  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating count of matches.
- count_sat  out  1  high while match_count is all ones.

## Operation
- State: pat_reg[WIDTH-1:0], hist[WIDTH-1:0] (hist[0] = newest bit), fill counter fill (0..WIDTH, saturates at WIDTH), cnt[CNT_W-1:0].
- Reset values: pat_reg=RST_PATTERN, hist=0, fill=0, Y=0, match_count=0, count_sat=0.
- On a sample cycle (in_valid=1, pattern_load=0):
  - nhist = {hist[WIDTH-2:0], A}
  - nfill = min(fill+1, WIDTH)
  - match = (nfill==WIDTH) && (nhist==pat_reg)
- Register updates on a sample cycle:
  - hist <= nhist.
  - Y <= match.
  - If match and OVERLAP=0: fill <= 0. Otherwise fill <= nfill.
  - If match and cnt is not all ones: cnt <= cnt+1.
- in_valid=0: hist, fill and cnt hold; Y <= 0.
- pattern_load=1, which has priority over in_valid: pat_reg <= pattern; hist <= 0; fill <= 0; cnt <= 0; Y <= 0. A bit presented in the same cycle is discarded.
- rst has priority over everything. Reset mid-stream discards partial history; the bits sampled before reset can never contribute to a match.
- No match is possible until WIDTH valid bits have been sampled since the last reset, pattern load, or non-overlapping match.
- count_sat = &match_count, derived combinationally from the register.

## Timing
- Latency: Y rises on the clock edge that samples the bit completing the pattern. It is visible for exactly one cycle after that edge.
- Back-to-back matches (OVERLAP=1, pattern such as 2'b11 with stream 1,1,1) give Y high on consecutive cycles.
- match_count updates on the same edge as Y.
- in_valid gaps are transparent: a pattern split by idle cycles still matches.
- Counter wrap-around is forbidden; cnt holds at 2^CNT_W-1.

## Structure
- Package seq_det_pkg holds:
  - MAX_WIDTH=16.
  - Default RST_PATTERN constant.
  - A function for the saturating increment, shared with future detector variants.
- Sub-module seq_shift_hist: the hist shift register plus the fill counter, with clear/shift/hold controls. The top level holds pat_reg, compare, mode logic and the counter.
- Static assertion: WIDTH must be in 2..MAX_WIDTH.

## Test plan
- WIDTH=2, RST_PATTERN=01, in_valid=1, stream 0,1,0,0,1,1 -> Y high after bits 2 and 5 only; match_count=2.
- WIDTH=3, pattern_load 3'b101, stream 1,0,1,0,1 -> OVERLAP=1: Y after bits 3 and 5, count=2. OVERLAP=0: Y after bit 3 only, count=1.
- WIDTH=2 pattern 01, stream 0,(in_valid=0 for 3 cycles),1 -> single Y pulse on the edge sampling the 1; Y=0 during the idle cycles.
- CNT_W=2, pattern 01, stream 0,1 repeated 5 times -> match_count sequence 1,2,3,3,3; count_sat=1 from the third match onward; Y still pulses 5 times.
- Stream 0, then rst for one cycle, then 1 -> no Y; after rst, stream 0,1 -> Y=1, count=1.
- Stream 0, then pattern_load 2'b10 together with in_valid=1, A=1 -> that bit is dropped, count=0; then stream 1,0 -> Y=1.

Source files
------------

// File: rtl/seq_pattern_detector_pkg.sv
// Shared constants and helpers for the serial sequence detector family.
package seq_det_pkg;

  localparam int MAX_WIDTH = 16;
  localparam logic [1:0] DEFAULT_RST_PATTERN = 2'b01;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    logic [31:0] res;
    if (val >= max_val) begin
      res = val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_pattern_detector_shift_hist.sv
// History shift register with a saturating count of valid bits collected since the last clear/restart.
module seq_shift_hist #(
  parameter int WIDTH  = 2,
  parameter int FILL_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic              restart,
  input  logic              bit_in,
  output logic [WIDTH-1:0]  hist,
  output logic [WIDTH-1:0]  next_hist,
  output logic [FILL_W-1:0] fill,
  output logic [FILL_W-1:0] next_fill
);

  logic [WIDTH-1:0]  hist_r;
  logic [FILL_W-1:0] fill_r;

  // Look-ahead values so the caller can compare against the bit being sampled now.
  always_comb begin
    next_hist = {hist_r[WIDTH-2:0], bit_in};
    if (fill_r == FILL_W'(WIDTH)) begin
      next_fill = fill_r;
    end else begin
      next_fill = fill_r + FILL_W'(1);
    end
  end

  // Clear beats shift; restart keeps the shifted history but empties the fill count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (shift) begin
      hist_r <= next_hist;
      if (restart) begin
        fill_r <= '0;
      end else begin
        fill_r <= next_fill;
      end
    end else begin
      hist_r <= hist_r;
      fill_r <= fill_r;
    end
  end

  assign hist = hist_r;
  assign fill = fill_r;

endmodule

// File: rtl/seq_pattern_detector.sv
// Loadable-pattern serial sequence detector with overlap/non-overlap modes
// and a saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int               WIDTH       = 2,
  parameter int               OVERLAP     = 1,
  parameter int               CNT_W       = 8,
  parameter logic [WIDTH-1:0] RST_PATTERN = WIDTH'(DEFAULT_RST_PATTERN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] pattern,
  input  logic             pattern_load,
  output logic             Y,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  generate
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("seq_pattern_detector: WIDTH must be within 2..MAX_WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0]  pat_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              y_r;
  logic [WIDTH-1:0]  hist_s;
  logic [WIDTH-1:0]  next_hist_s;
  logic [FILL_W-1:0] fill_s;
  logic [FILL_W-1:0] next_fill_s;
  logic              sample_s;
  logic              match_s;
  logic              restart_s;
  logic [CNT_W-1:0]  cnt_next_s;

  seq_shift_hist #(
    .WIDTH  (WIDTH),
    .FILL_W (FILL_W)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .clear     (pattern_load),
    .shift     (in_valid),
    .restart   (restart_s),
    .bit_in    (A),
    .hist      (hist_s),
    .next_hist (next_hist_s),
    .fill      (fill_s),
    .next_fill (next_fill_s)
  );

  // Match needs a full window of fresh bits equal to the loaded pattern.
  always_comb begin
    sample_s = in_valid & ~pattern_load;
    if (sample_s && (next_fill_s == FILL_W'(WIDTH)) && (next_hist_s == pat_r)) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
    if (match_s && (OVERLAP == 0)) begin
      restart_s = 1'b1;
    end else begin
      restart_s = 1'b0;
    end
    cnt_next_s = CNT_W'(sat_inc(32'(cnt_r), 32'(CNT_MAX)));
  end

  // Pattern register, match pulse and saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r <= RST_PATTERN;
      cnt_r <= '0;
      y_r   <= 1'b0;
    end else if (pattern_load) begin
      pat_r <= pattern;
      cnt_r <= '0;
      y_r   <= 1'b0;
    end else if (in_valid) begin
      y_r <= match_s;
      if (match_s) begin
        cnt_r <= cnt_next_s;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      y_r <= 1'b0;
    end
  end

  assign Y           = y_r;
  assign match_count = cnt_r;
  assign count_sat   = &cnt_r;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Four detector configurations share one stimulus stream; a bit-log model predicts every output each cycle.
module tb_seq_pattern_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        a = 1'b0;
  logic        in_valid = 1'b0;
  logic        pattern_load = 1'b0;
  logic [15:0] pattern = 16'h0;

  logic [3:0]  y;
  logic [3:0]  sat;
  logic [7:0]  mc0, mc1, mc2;
  logic [1:0]  mc3;
  logic [7:0]  mc [4];

  assign mc[0] = mc0;
  assign mc[1] = mc1;
  assign mc[2] = mc2;
  assign mc[3] = {6'b0, mc3};

  seq_pattern_detector #(.WIDTH(2), .OVERLAP(1), .CNT_W(8), .RST_PATTERN(2'b01)) u0 (
    .clk(clk), .rst(rst), .A(a), .in_valid(in_valid), .pattern(pattern[1:0]),
    .pattern_load(pattern_load), .Y(y[0]), .match_count(mc0), .count_sat(sat[0]));
  seq_pattern_detector #(.WIDTH(3), .OVERLAP(1), .CNT_W(8), .RST_PATTERN(3'b110)) u1 (
    .clk(clk), .rst(rst), .A(a), .in_valid(in_valid), .pattern(pattern[2:0]),
    .pattern_load(pattern_load), .Y(y[1]), .match_count(mc1), .count_sat(sat[1]));
  seq_pattern_detector #(.WIDTH(3), .OVERLAP(0), .CNT_W(8), .RST_PATTERN(3'b110)) u2 (
    .clk(clk), .rst(rst), .A(a), .in_valid(in_valid), .pattern(pattern[2:0]),
    .pattern_load(pattern_load), .Y(y[2]), .match_count(mc2), .count_sat(sat[2]));
  seq_pattern_detector #(.WIDTH(2), .OVERLAP(1), .CNT_W(2), .RST_PATTERN(2'b01)) u3 (
    .clk(clk), .rst(rst), .A(a), .in_valid(in_valid), .pattern(pattern[1:0]),
    .pattern_load(pattern_load), .Y(y[3]), .match_count(mc3), .count_sat(sat[3]));

  int          lw   [4] = '{2, 3, 3, 2};
  int          lov  [4] = '{1, 1, 0, 1};
  int          lcw  [4] = '{8, 8, 8, 2};
  logic [15:0] lrst [4] = '{16'b01, 16'b110, 16'b110, 16'b01};

  // Model: every accepted bit goes into one log; each lane remembers where its window may start.
  bit          log_bits [$];
  logic [15:0] mpat   [4];
  int          mstart [4];
  logic        ey     [4];
  int          ecnt   [4];
  int          ytally [4] = '{0, 0, 0, 0};

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int cmax(input int l);
    return (1 << lcw[l]) - 1;
  endfunction

  function automatic bit tail_match(input int l);
    int n;
    n = log_bits.size();
    if (n - mstart[l] < lw[l]) return 1'b0;
    for (int k = 0; k < lw[l]; k++) begin
      if (log_bits[n-1-k] != mpat[l][k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle model update and comparison of all four lanes.
  initial begin
    logic        s_rst, s_a, s_v, s_ld;
    logic [15:0] s_p;
    forever begin
      @(posedge clk);
      s_rst = rst; s_a = a; s_v = in_valid; s_ld = pattern_load; s_p = pattern;
      if (!s_rst && !s_ld && s_v) log_bits.push_back(s_a);
      for (int l = 0; l < 4; l++) begin
        if (s_rst) begin
          mpat[l] = lrst[l]; mstart[l] = log_bits.size(); ey[l] = 1'b0; ecnt[l] = 0;
        end else if (s_ld) begin
          mpat[l] = s_p & ((16'h1 << lw[l]) - 16'h1);
          mstart[l] = log_bits.size(); ey[l] = 1'b0; ecnt[l] = 0;
        end else if (s_v) begin
          ey[l] = tail_match(l);
          if (ey[l]) begin
            if (ecnt[l] < cmax(l)) ecnt[l] = ecnt[l] + 1;
            if (lov[l] == 0) mstart[l] = log_bits.size();
          end
        end else begin
          ey[l] = 1'b0;
        end
      end
      #1;
      for (int l = 0; l < 4; l++) begin
        chk($sformatf("y_lane%0d", l), 32'(y[l]), 32'(ey[l]));
        chk($sformatf("count_lane%0d", l), 32'(mc[l]), 32'(ecnt[l]));
        chk($sformatf("sat_lane%0d", l), 32'(sat[l]), (ecnt[l] == cmax(l)) ? 32'd1 : 32'd0);
        if (y[l] === 1'b1) ytally[l]++;
      end
    end
  end

  task automatic drive(input logic b, input logic v, input logic ld, input logic r, input logic [15:0] p);
    @(negedge clk);
    a = b; in_valid = v; pattern_load = ld; rst = r; pattern = p;
  endtask

  task automatic send(input logic b);
    drive(b, 1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int base [4];
    bit s1 [6] = '{0, 1, 0, 0, 1, 1};
    bit s2 [5] = '{1, 0, 1, 0, 1};
    int s4 [5] = '{1, 2, 3, 3, 3};
    int r;

    do_reset();
    do_reset();
    settle();
    chk("reset_y0", 32'(y[0]), 32'd0);
    chk("reset_count0", 32'(mc[0]), 32'd0);
    chk("reset_sat3", 32'(sat[3]), 32'd0);

    // Pattern 01 over 0,1,0,0,1,1
    do_reset();
    base = ytally;
    foreach (s1[i]) send(s1[i]);
    settle();
    chk("s1_count", 32'(mc[0]), 32'd2);
    chk("s1_pulses", 32'(ytally[0] - base[0]), 32'd2);
    chk("s1_model_count", 32'(ecnt[0]), 32'd2);

    // Load 101, stream 1,0,1,0,1: overlap vs restart
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'b101);
    base = ytally;
    foreach (s2[i]) send(s2[i]);
    settle();
    chk("s2_overlap_count", 32'(mc[1]), 32'd2);
    chk("s2_nonoverlap_count", 32'(mc[2]), 32'd1);
    chk("s2_overlap_pulses", 32'(ytally[1] - base[1]), 32'd2);
    chk("s2_nonoverlap_pulses", 32'(ytally[2] - base[2]), 32'd1);
    chk("s2_model_nonoverlap", 32'(ecnt[2]), 32'd1);

    // Idle gap inside the pattern
    do_reset();
    base = ytally;
    send(1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    send(1'b1);
    settle();
    chk("s3_count", 32'(mc[0]), 32'd1);
    chk("s3_pulses", 32'(ytally[0] - base[0]), 32'd1);

    // Two-bit counter saturation
    do_reset();
    base = ytally;
    for (int i = 0; i < 5; i++) begin
      send(1'b0);
      send(1'b1);
      settle();
      chk($sformatf("s4_count_step%0d", i), 32'(mc[3]), 32'(s4[i]));
      chk($sformatf("s4_sat_step%0d", i), 32'(sat[3]), (i >= 2) ? 32'd1 : 32'd0);
    end
    chk("s4_pulses", 32'(ytally[3] - base[3]), 32'd5);

    // Reset between the two halves of a match
    do_reset();
    base = ytally;
    send(1'b0);
    do_reset();
    send(1'b1);
    settle();
    chk("s5_no_pulse", 32'(ytally[0] - base[0]), 32'd0);
    send(1'b0);
    send(1'b1);
    settle();
    chk("s5_count", 32'(mc[0]), 32'd1);

    // Load drops the bit presented with it
    do_reset();
    send(1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'b10);
    settle();
    chk("s6_count_after_load", 32'(mc[0]), 32'd0);
    base = ytally;
    send(1'b1);
    send(1'b0);
    settle();
    chk("s6_count", 32'(mc[0]), 32'd1);
    chk("s6_pulses", 32'(ytally[0] - base[0]), 32'd1);

    // Random traffic
    do_reset();
    repeat (3000) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        do_reset();
      end else if (r < 3) begin
        drive(1'($urandom), 1'($urandom), 1'b1, 1'b0, 16'($urandom));
      end else begin
        drive(1'($urandom), ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, 1'b0, 1'b0, 16'h0);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
